// File: rtl/cic3_comp_pkg.sv
// Shared widths, droop-compensation coefficients and FSM states for the
// CIC3 compensation FIR decimator.
package cic3_comp_pkg;

  localparam int DATA_WIDTH_DEF = 25;
  localparam int COEF_WIDTH_DEF = 16;
  localparam int NTAPS_DEF      = 16;
  localparam int DECIM_DEF      = 2;
  localparam int ACC_WIDTH_DEF  = 45;

  // Symmetric Q1.15 taps summing to 32768, so a constant input passes at unity gain.
  localparam logic signed [COEF_WIDTH_DEF-1:0] COEFS [NTAPS_DEF] = '{
    -16'sd60,   16'sd110,   16'sd220,  -16'sd380,
    -16'sd640,  16'sd1100,  16'sd3400,  16'sd12634,
     16'sd12634, 16'sd3400, 16'sd1100, -16'sd640,
    -16'sd380,  16'sd220,   16'sd110,  -16'sd60
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } state_e;

endpackage

// File: rtl/cic3_comp_sample_buf.sv
// Circular sample history: one write port that advances its own pointer,
// one combinational read port addressed by the MAC sequencer.
module cic3_comp_sample_buf
  import cic3_comp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NTAPS      = NTAPS_DEF,
  parameter int ADDR_WIDTH = $clog2(NTAPS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o
);

  logic [DATA_WIDTH-1:0] mem_q [NTAPS];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q        <= wr_ptr_q + ADDR_WIDTH'(1);
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];
  assign wr_ptr_o  = wr_ptr_q;

endmodule

// File: rtl/cic3_comp_fir.sv
// Droop-compensating FIR decimator behind the CIC3: one shared MAC walks the
// taps one per clock, then rounds and saturates into a registered output.
module cic3_comp_fir
  import cic3_comp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int NTAPS      = NTAPS_DEF,
  parameter int DECIM      = DECIM_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int AW         = $clog2(NTAPS);
  localparam int PW         = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);
  localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) <<< (COEF_WIDTH - 2);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_e                         state_q, state_d;
  logic [AW-1:0]                  tap_q, tap_d;
  logic [AW-1:0]                  base_q, base_d;
  logic [PW-1:0]                  phase_q, phase_d;
  logic                           hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]          hold_q, hold_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                           dout_valid_q, dout_valid_d;
  logic                           overrun_q, overrun_d;

  logic                           wr_en;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [AW-1:0]                  wr_ptr;
  logic signed [DATA_WIDTH-1:0]   rd_data;
  logic signed [COEF_WIDTH-1:0]   coef_k;
  logic signed [PROD_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0]    rnd;
  logic signed [ACC_WIDTH-1:0]    shifted;
  logic signed [DATA_WIDTH-1:0]   y_sat;

  cic3_comp_sample_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NTAPS      (NTAPS),
    .ADDR_WIDTH (AW)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_addr_i (base_q - tap_q),
    .rd_data_o (rd_data),
    .wr_ptr_o  (wr_ptr)
  );

  assign coef_k = COEFS[tap_q];
  assign prod   = PROD_WIDTH'(coef_k) * PROD_WIDTH'(rd_data);

  // Round half-up at the Q1.15 point, then clamp instead of wrapping.
  always_comb begin
    rnd     = acc_q + ROUND_BIAS;
    shifted = rnd >>> (COEF_WIDTH - 1);
    if (shifted > SAT_MAX)      y_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) y_sat = SAT_MIN[DATA_WIDTH-1:0];
    else                        y_sat = shifted[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    base_d       = base_q;
    phase_d      = phase_q;
    hold_full_d  = hold_full_q;
    hold_d       = hold_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;
    wr_data      = din;

    if (overrun_clr) overrun_d = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      phase_d     = '0;
      hold_full_d = 1'b0;
    end else begin
      // A parked sample has priority over a fresh one; the fresh one takes its slot.
      if (state_q == IDLE) begin
        if (hold_full_q) begin
          wr_en       = 1'b1;
          wr_data     = hold_q;
          hold_full_d = din_valid;
          if (din_valid) hold_d = din;
        end else if (din_valid) begin
          wr_en = 1'b1;
        end
      end else if (din_valid) begin
        if (hold_full_q) begin
          overrun_d = 1'b1;
        end else begin
          hold_full_d = 1'b1;
          hold_d      = din;
        end
      end

      if (wr_en) begin
        phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
        if (phase_q == LAST_PHASE) begin
          state_d = MAC;
          base_d  = wr_ptr;
          tap_d   = '0;
          acc_d   = '0;
        end
      end

      case (state_q)
        MAC: begin
          acc_d = acc_q + ACC_WIDTH'(prod);
          tap_d = tap_q + AW'(1);
          if (tap_q == LAST_TAP) state_d = ROUND;
        end
        ROUND: begin
          dout_d       = y_sat;
          dout_valid_d = 1'b1;
          state_d      = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      base_q       <= '0;
      phase_q      <= '0;
      hold_full_q  <= 1'b0;
      hold_q       <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      base_q       <= base_d;
      phase_q      <= phase_d;
      hold_full_q  <= hold_full_d;
      hold_q       <= hold_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE) || dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic3_comp_fir.sv
// Directed bench for cic3_comp_fir: an arithmetic FIR model predicts every
// output value and its arrival cycle, with literal pins on key results.
module tb_cic3_comp_fir;

  localparam int DECIM   = 2;
  localparam int LAT     = 18;
  localparam int FS_POS  = 16777215;
  localparam int FS_NEG  = -16777216;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b1;
  logic [24:0] din = '0;
  logic        din_valid = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [24:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        overrun;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int coef [16] = '{-60, 110, 220, -380, -640, 1100, 3400, 12634,
                    12634, 3400, 1100, -640, -380, 220, 110, -60};
  int imp_lit [9] = '{110, -380, 1100, 12634, 3400, -640, 220, -60, 0};

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t expq[$];
  int   hist[$];
  int   mphase = 0;
  exp_t cur;
  logic exp_busy;

  cic3_comp_fir dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .din         (din),
    .din_valid   (din_valid),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Plain convolution of the newest 16 accepted samples, rounded half-up and clamped.
  function automatic int model_output();
    longint acc = 0;
    longint y;
    for (int k = 0; k < 16; k++) begin
      int idx = hist.size() - 1 - k;
      if (idx >= 0) acc += longint'(coef[k]) * longint'(hist[idx]);
    end
    y = (acc + 64'sd16384) >>> 15;
    if (y > FS_POS) y = FS_POS;
    if (y < FS_NEG) y = FS_NEG;
    return int'(y);
  endfunction

  function automatic void model_accept(input int s, input int c);
    hist.push_back(s);
    if (hist.size() > 16) void'(hist.pop_front());
    if (mphase == DECIM - 1) begin
      exp_t e;
      e.val = model_output();
      e.cyc = c + LAT;
      expq.push_back(e);
      mphase = 0;
    end else begin
      mphase++;
    end
  endfunction

  function automatic void model_abort();
    expq.delete();
    mphase = 0;
  endfunction

  function automatic void model_reset();
    expq.delete();
    hist.delete();
    mphase = 0;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      exp_busy = 1'b0;
      foreach (expq[i])
        if (cyc >= expq[i].cyc - (LAT - 1) && cyc <= expq[i].cyc) exp_busy = 1'b1;
      check("busy", busy, exp_busy);
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        cur = expq.pop_front();
        check("dout_valid", dout_valid, 1);
        if (dout_valid) check("dout", $signed(dout), cur.val);
      end else begin
        check("dout_valid_idle", dout_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic applyStimulus(input int s);
    din       = 25'(s);
    din_valid = 1'b1;
    model_accept(s, cyc);
    tick();
    din_valid = 1'b0;
    repeat (19) tick();
  endtask

  task automatic pulse(input int s);
    din       = 25'(s);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int want);
    check(name, $signed(dout), want);
  endtask

  task automatic run_impulse(input string tag);
    applyStimulus(32768);
    for (int i = 1; i < 18; i++) begin
      applyStimulus(0);
      if (i % 2 == 1) checkOutput({tag, "_tap"}, imp_lit[i / 2]);
    end
  endtask

  initial begin
    int t;
    #1 reset_n = 1'b0;
    #2;
    check("reset_dout", $signed(dout), 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] impulse");
    run_impulse("imp1");

    $display("[TB] dc");
    for (int i = 0; i < 16; i++) applyStimulus(1000);
    checkOutput("dc_pos", 1000);
    for (int i = 0; i < 16; i++) applyStimulus(-1000);
    checkOutput("dc_neg", -1000);

    $display("[TB] saturation");
    for (int i = 0; i < 16; i++) applyStimulus(0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(FS_POS);
      if (i == 3)  checkOutput("sat_pos_undershoot", -56320);
      if (i == 11) checkOutput("sat_pos_peak", FS_POS);
    end
    checkOutput("sat_pos_final", FS_POS);
    for (int i = 0; i < 16; i++) applyStimulus(0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(FS_NEG);
      if (i == 11) checkOutput("sat_neg_peak", FS_NEG);
    end
    checkOutput("sat_neg_final", FS_NEG);

    $display("[TB] overrun");
    applyStimulus(5000);
    t = cyc;
    din = 25'(-7000);
    din_valid = 1'b1;
    model_accept(-7000, t);
    tick();
    din_valid = 1'b0;
    to_cycle(t + 2);
    pulse(9000);
    model_accept(9000, t + LAT);
    @(negedge clk) check("overrun_after_hold", overrun, 0);
    to_cycle(t + 4);
    pulse(111111);
    @(negedge clk) check("overrun_set", overrun, 1);
    to_cycle(t + 6);
    pulse(222222);
    to_cycle(t + 7);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    @(negedge clk) check("overrun_clear", overrun, 0);
    to_cycle(t + 9);
    overrun_clr = 1'b1;
    pulse(333333);
    overrun_clr = 1'b0;
    @(negedge clk) check("overrun_set_wins", overrun, 1);
    to_cycle(t + 11);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    @(negedge clk) check("overrun_clear2", overrun, 0);
    to_cycle(t + 22);
    applyStimulus(3000);

    $display("[TB] abort");
    applyStimulus(4000);
    t = cyc;
    din = 25'(6000);
    din_valid = 1'b1;
    model_accept(6000, t);
    tick();
    din_valid = 1'b0;
    to_cycle(t + 5);
    enable = 1'b0;
    tick();
    model_abort();
    @(negedge clk) check("abort_busy", busy, 0);
    tick();
    pulse(77777);
    repeat (25) tick();
    enable = 1'b1;
    din = 25'(-2500);
    din_valid = 1'b1;
    model_accept(-2500, cyc);
    tick();
    din_valid = 1'b0;
    repeat (19) tick();
    applyStimulus(1500);

    $display("[TB] reset mid-MAC");
    applyStimulus(8000);
    t = cyc;
    din = 25'(2000);
    din_valid = 1'b1;
    model_accept(2000, t);
    tick();
    din_valid = 1'b0;
    to_cycle(t + 6);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("midreset_dout", $signed(dout), 0);
    check("midreset_dout_valid", dout_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_overrun", overrun, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_impulse("imp2");

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
